// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, inst} entries; the head is a register so decode
// sees stable outputs that keep their last value once the queue drains.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output logic         valid,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] remain;

  assign do_pop  = pop && (cnt != '0);
  assign rd_next = rd_ptr + AW'(do_pop);
  assign remain  = cnt - CW'(do_pop);
  assign count   = cnt;
  assign valid   = (cnt != '0);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // The next head is the oldest surviving entry, or the incoming push when
  // nothing older remains; with neither, the head keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      cnt    <= remain + CW'(push);
      if (remain != '0) begin
        head <= mem[rd_next];
      end else if (push) begin
        head <= push_entry;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, imem requests and prefetch queue to decode.
// Define FETCH_PERF_EN to add the stall_cnt port counting empty RUN cycles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            credit_ok;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Queued entries plus the one outstanding response must fit in the queue.
  assign credit_ok = (count + CW'(inflight)) < CW'(DEPTH);

  always_comb begin
    imem_req = 1'b0;
    if (!redirect) begin
      case (state)
        RUN:      imem_req = credit_ok;
        REDIRECT: imem_req = 1'b1;
        default:  imem_req = 1'b0;
      endcase
    end
  end

  assign imem_addr  = fetch_pc[31:2];
  assign push       = inflight && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign push_entry = '{pc: req_pc, inst: imem_rdata};
  assign inst_out   = head.inst;
  assign pc_out     = head.pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc & ~32'h3;
        state    <= REDIRECT;
      end else begin
        if (imem_req) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (state != RUN) begin
          state <= RUN;
        end
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .valid      (inst_valid),
    .head       (head)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state == RUN && !inst_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
